// File: rtl/lsu.sv
// lsu: load/store unit driving a req/gnt + rvalid data-memory bus.
// Optional macro LSU_MISALIGN_EXC_EN traps misaligned half/word accesses.
`ifndef XLEN
`define XLEN 32
`endif

module lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_valid_i,
    input  logic              lsu_load_i,
    input  logic              lsu_store_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_unsigned_i,
    input  logic [`XLEN-1:0]  lsu_addr_i,
    input  logic [`XLEN-1:0]  lsu_wdata_i,
    output logic [`XLEN-1:0]  lsu_rd_wdata_o,
    output logic              lsu_done_o,
    output logic              lsu_stall_o,
    output logic              lsu_err_o,
    output logic              lsu_misalign_o,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [`XLEN-1:0]  dmem_addr_o,
    output logic [`XLEN-1:0]  dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [`XLEN-1:0]  dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q;
    logic [`XLEN-1:0]  addr_q, wdata_q, rdata_q;
    logic [3:0]        be_q;
    logic [1:0]        size_q, off_q;
    logic              we_q, uns_q, err_q, mis_q;

    logic              accept, misalign, busy;
    logic              timeout, to_abort;
    logic [1:0]        off_raw, off_eff;
    logic [3:0]        be_d;
    logic [`XLEN-1:0]  wdata_d, shifted, ext;

    assign off_raw = lsu_addr_i[1:0];
    assign accept  = (state_q == IDLE) & lsu_valid_i
                   & (lsu_load_i | lsu_store_i);
    assign busy    = (state_q == REQ) | (state_q == WAIT);
    assign timeout = busy & (cnt_q >= TO_LAST);

`ifdef LSU_MISALIGN_EXC_EN
    assign misalign = ((lsu_size_i == 2'b01) & off_raw[0])
                    | (lsu_size_i[1] & (|off_raw));
`else
    assign misalign = 1'b0;
`endif

    // Lane placement: byte enables and replicated store data per size.
    always_comb begin
        off_eff = 2'b00;
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                off_eff = off_raw;
                be_d    = 4'b0001 << off_raw;
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                off_eff = {off_raw[1], 1'b0};
                be_d    = 4'b0011 << {off_raw[1], 1'b0};
                wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                off_eff = 2'b00;
                be_d    = 4'b1111;
                wdata_d = lsu_wdata_i;
            end
        endcase
    end

    // Load alignment: shift the addressed lane down, then extend.
    always_comb begin
        shifted = dmem_rdata_i >> {off_q, 3'b000};
        ext     = shifted;
        case (size_q)
            2'b00:
                ext = {{(`XLEN-8){~uns_q & shifted[7]}},
                       shifted[7:0]};
            2'b01:
                ext = {{(`XLEN-16){~uns_q & shifted[15]}},
                       shifted[15:0]};
            default:
                ext = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; bus progress beats a same-cycle timeout.
    always_comb begin
        state_d  = state_q;
        to_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = misalign ? DONE : REQ;
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d  = DONE;
                    to_abort = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d  = DONE;
                    to_abort = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter: zero outside REQ/WAIT, counts while busy.
    always_ff @(posedge clk_i) begin
        if (rst_i || !busy) cnt_q <= '0;
        else                cnt_q <= cnt_q + 16'd1;
    end

    // Transaction registers captured at accept, load data at rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= {lsu_addr_i[`XLEN-1:2], 2'b00};
                wdata_q <= wdata_d;
                rdata_q <= '0;
                be_q    <= be_d;
                size_q  <= lsu_size_i;
                off_q   <= off_eff;
                we_q    <= lsu_store_i;
                uns_q   <= lsu_unsigned_i;
                err_q   <= 1'b0;
                mis_q   <= misalign;
            end
            if (state_q == WAIT && dmem_rvalid_i && !we_q)
                rdata_q <= ext;
            if (to_abort)
                err_q <= 1'b1;
        end
    end

    // Outputs: bus only driven in REQ, results only in DONE.
    always_comb begin
        dmem_req_o     = 1'b0;
        dmem_we_o      = 1'b0;
        dmem_be_o      = 4'b0000;
        dmem_addr_o    = '0;
        dmem_wdata_o   = '0;
        lsu_done_o     = 1'b0;
        lsu_rd_wdata_o = '0;
        lsu_err_o      = 1'b0;
        lsu_misalign_o = 1'b0;
        unique case (state_q)
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_be_o    = be_q;
                dmem_addr_o  = addr_q;
                dmem_wdata_o = wdata_q;
            end
            DONE: begin
                lsu_done_o     = 1'b1;
                lsu_rd_wdata_o = rdata_q;
                lsu_err_o      = err_q;
                lsu_misalign_o = mis_q;
            end
            default: begin
                lsu_done_o = 1'b0;
            end
        endcase
    end

    assign lsu_stall_o = lsu_valid_i & ~lsu_done_o;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit on the memory side of the execute stage.
- Consumes the AGU address, store data and decoded load/store controls, and runs one transaction on the data-memory bus (req/gnt request phase, rvalid response phase).
- Returns the sign/zero-extended load result to writeback.
- Stalls the core until the access completes, errors out or times out.

Parameters:
- BUS_TIMEOUT, 255: max cycles spent in REQ+WAIT before aborting with an error (1..65535).

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous active-high reset
- lsu_valid_i  input  1  load/store instruction present; held high by the core until lsu_done_o
- lsu_load_i  input  1  access is a load
- lsu_store_i  input  1  access is a store (load and store never both high)
- lsu_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- lsu_unsigned_i  input  1  zero-extend load (LBU/LHU)
- lsu_addr_i  input  `XLEN  byte address from the AGU
- lsu_wdata_i  input  `XLEN  rs2 store data
- lsu_rd_wdata_o  output  `XLEN  extended load result; valid while lsu_done_o=1
- lsu_done_o  output  1  one-cycle completion pulse
- lsu_stall_o  output  1  lsu_valid_i & ~lsu_done_o
- lsu_err_o  output  1  bus timeout; coincides with lsu_done_o
- lsu_misalign_o  output  1  misaligned access; coincides with lsu_done_o (feature-gated)
- dmem_req_o  output  1  bus request
- dmem_gnt_i  input  1  request accepted
- dmem_we_o  output  1  write enable
- dmem_be_o  output  4  byte enables
- dmem_addr_o  output  `XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  output  `XLEN  lane-replicated store data
- dmem_rvalid_i  input  1  response valid (loads and stores)
- dmem_rdata_i  input  `XLEN  load response data

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, timeout counter 0, all outputs 0. lsu_stall_o is combinational and follows lsu_valid_i.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If lsu_valid_i & (lsu_load_i | lsu_store_i): register addr, size, unsigned, we, be and wdata.
  - Go to REQ, or to DONE if misaligned (feature on).
  - No bus activity in IDLE.
- REQ:
  - dmem_req_o=1; addr/we/be/wdata held stable until gnt.
  - On dmem_gnt_i go to WAIT; req deasserts the next cycle.
- WAIT:
  - dmem_req_o=0.
  - On dmem_rvalid_i, for loads capture extended dmem_rdata_i into lsu_rd_wdata_o; go to DONE.
  - Stores also wait for rvalid; rdata is ignored and lsu_rd_wdata_o=0.
- DONE: lsu_done_o=1 for exactly one cycle; next state IDLE. lsu_valid_i is not sampled in DONE.
- Minimum latency: accept in cycle 0; gnt and rvalid immediate; lsu_done_o in cycle 3.
- Lane rules (off = addr[1:0]):
  - Byte: be = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111, wdata unchanged.
  - Loads: shift dmem_rdata_i right by 8*off, take size bits, sign-extend unless lsu_unsigned_i.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches BUS_TIMEOUT without progress: go to DONE with lsu_err_o=1, lsu_rd_wdata_o=0, req dropped.
  - gnt or rvalid in the same cycle as the timeout wins (normal progress).
- Ignored inputs:
  - rvalid while in REQ or IDLE (stale/late response).
  - gnt while in WAIT, DONE or IDLE.
- Reset mid-transaction: immediate return to IDLE, req low. The outstanding response is dropped when it arrives.
- lsu_valid_i high with neither load nor store: no action, lsu_done_o never pulses (decoder guarantees this does not occur).

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE->DONE with lsu_misalign_o=1.
  - No bus request; lsu_rd_wdata_o=0.
- Undefined:
  - lsu_misalign_o tied 0.
  - Misaligned accesses proceed with the offset forced to 0 for half (off&2) and word (off=0), i.e. aligned down.

Test Plan:
- LW addr=0x100, gnt and rvalid immediate, rdata=0xDEADBEEF -> dmem_addr_o=0x100, be=1111, done in cycle 3, lsu_rd_wdata_o=0xDEADBEEF.
- LB addr=0x103, rdata=0x80112233 -> be=1000, result 0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, gnt delayed 3 cycles -> req/addr/be=1100/wdata=0xABCDABCD stable all 4 REQ cycles, we=1, done after rvalid.
- Load with no rvalid, BUS_TIMEOUT=8 -> lsu_err_o and lsu_done_o pulse together 8 cycles after entering REQ; a later rvalid is ignored in IDLE.
- LW addr=0x101 with LSU_MISALIGN_EXC_EN -> no dmem_req_o, lsu_misalign_o=1 with done in cycle 1; without macro -> access to 0x100, be=1111.
- rst_i asserted in WAIT -> next cycle state IDLE, all outputs 0; following rvalid produces no done.
